exc_ctrl: RTL and testbench
===========================

// Module: exc_ctrl
// PURPOSE
// - Exception/interrupt controller directly upstream of the CP0 register block in the dynamic pipeline.
// - Collects syscall/break/teq/eret requests from the EX stage and an optional external IRQ, and selects one event.
// - Drives CP0's exception/eret/cause/pc inputs, flushes younger pipeline stages and requests the PC redirect to CP0's exc_addr.
// PARAMETERS
// - FLUSH_CYCLES  2  cycles flush stays high after an accepted event (1..7)
// - SYNC_STAGES   2  IRQ synchronizer depth (>=2); used only with IRQ_EN
// PORTS
// - clk          in   1   clock; all state updates on posedge
// - rst          in   1   asynchronous, active-low reset
// - ex_valid     in   1   EX stage holds a valid instruction
// - ex_stall     in   1   pipeline stall; no event accepted while high
// - ex_pc        in   32  PC of the EX instruction
// - ex_syscall   in   1   syscall in EX
// - ex_break     in   1   break in EX
// - ex_teq_trap  in   1   teq condition true in EX
// - ex_eret      in   1   eret in EX
// - status_ie    in   1   CP0 Status bit 0 (interrupt enable)
// - irq          in   1   external interrupt line, async, level
// - exception    out  1   to CP0 exception
// - eret         out  1   to CP0 eret
// - cause        out  5   to CP0 cause (ExcCode)
// - epc          out  32  to CP0 pc
// - flush        out  1   squash IF/ID/EX
// - pc_redirect  out  1   select CP0 exc_addr as next PC
// - busy         out  1   controller not in IDLE
// BEHAVIOUR
// - Reset (rst=0, any time incl. mid-flush): state IDLE; all outputs 0, epc=0; IRQ pending and synchronizer cleared.
// - States: IDLE -> FLUSH on accept; FLUSH counts FLUSH_CYCLES-1 further cycles -> IDLE.
// - Accept in IDLE when ex_valid=1, ex_stall=0, and any request is present (or an IRQ is takeable).
// - Priority: eret > teq_trap > break > syscall > IRQ. Exactly one event per accept.
// - ExcCode: syscall=8, break=9, teq=13, IRQ=0; eret leaves cause unchanged.
// - Accept sampled at posedge N. During cycle N+1 (registered):
//   - exception=1 for exactly one cycle; eret=1 in the same cycle for eret (CP0 restores status only with both high).
//   - epc=ex_pc captured at N and held until the next accept.
//   - pc_redirect=1 for one cycle.
//   - flush=1 for cycles N+1..N+FLUSH_CYCLES.
//   - busy=1 for the same window.
// - CP0 samples on negedge. All outputs are registered and stable across the negedge of cycle N+1.
// - Requests arriving while busy=1 are ignored: those instructions are being flushed.
// - Requests with ex_valid=0 or ex_stall=1 are ignored; nothing is latched for them.
// - IRQ pending is set on a rising edge of the synchronized irq.
//   - Takeable when pending=1, status_ie=1, ex_valid=1, ex_stall=0, state IDLE, and no instruction request that cycle.
//   - Instruction request wins over IRQ; pending is kept. Pending is cleared when the IRQ is taken.
//   - status_ie=0 holds pending indefinitely.
//   - The EX instruction is squashed; epc=ex_pc so it re-executes after eret.
// - A pending set and a take in the same cycle leave pending=1. IRQ edges during busy still set pending.
// CONFIGURATION
// - IRQ_EN defined: synchronizer, pending flag and IRQ arbitration are present as above.
// - IRQ_EN undefined: irq and status_ie are ignored (no logic); only instruction events are handled; cause is never 0.
// TESTING
// - ex_valid=1, ex_syscall=1, ex_pc=0x00400020 -> next cycle exception=1, cause=8, epc=0x00400020, pc_redirect=1; flush high 2 cycles.
// - ex_eret=1 together with ex_break=1 -> exception=1, eret=1, cause unchanged, break dropped.
// - ex_teq_trap=1 with ex_stall=1 for 3 cycles, then stall=0 -> no output until stall drops; then cause=13 one cycle later.
// - [IRQ_EN] irq rises with status_ie=0 for 10 cycles, then status_ie=1, ex_pc=0x00400100 -> one exception, cause=0, epc=0x00400100; pending cleared.
// - [IRQ_EN] irq edge and ex_syscall in the same accept cycle -> syscall taken (cause=8); after FLUSH the IRQ is taken (cause=0).
// - rst low in the first FLUSH cycle -> flush/exception/busy=0 immediately; after release, state IDLE and no stale event.

Source files
------------

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception/interrupt arbiter feeding CP0, flush and PC redirect
// Optional IRQ path (synchronizer, pending flag, IRQ arbitration) enabled by IRQ_EN.
module exc_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  logic [31:0] ex_pc,
    input  logic        ex_syscall,
    input  logic        ex_break,
    input  logic        ex_teq_trap,
    input  logic        ex_eret,
    input  logic        status_ie,
    input  logic        irq,
    output logic        exception,
    output logic        eret,
    output logic [4:0]  cause,
    output logic [31:0] epc,
    output logic        flush,
    output logic        pc_redirect,
    output logic        busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    localparam logic [2:0] C_CNT_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_cnt;
    logic        w_req;
    logic        w_accept_instr;
    logic        w_irq_take;
    logic        w_accept;
    logic [4:0]  w_code;
    logic        r_exception;
    logic        r_eret;
    logic [4:0]  r_cause;
    logic [31:0] r_epc;
    logic        r_redirect;

    assign w_req          = ex_syscall | ex_break | ex_teq_trap | ex_eret;
    assign w_accept_instr = (r_state == S_IDLE) & ex_valid & ~ex_stall & w_req;
    assign w_accept       = w_accept_instr | w_irq_take;

    // IRQ code 0 falls out naturally: an IRQ is only taken when no request bit is set
    assign w_code = ex_teq_trap ? 5'd13 :
                    ex_break    ? 5'd9  :
                    ex_syscall  ? 5'd8  : 5'd0;

`ifdef IRQ_EN
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_irq_d;
    logic                   r_pend;
    logic                   w_irq_rise;

    assign w_irq_rise = r_sync[SYNC_STAGES-1] & ~r_irq_d;
    assign w_irq_take = (r_state == S_IDLE) & ex_valid & ~ex_stall & ~w_req
                      & r_pend & status_ie;

    // A new edge wins over a take in the same cycle so that edge is not lost
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync  <= '0;
            r_irq_d <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], irq};
            r_irq_d <= r_sync[SYNC_STAGES-1];
            if (w_irq_rise)
                r_pend <= 1'b1;
            else if (w_irq_take)
                r_pend <= 1'b0;
        end
    end
`else
    logic w_unused;
    assign w_irq_take = 1'b0;
    assign w_unused   = irq ^ status_ie;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_FLUSH;
            S_FLUSH: if (r_cnt == 3'd0) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cnt <= 3'd0;
        else if (w_accept)
            r_cnt <= C_CNT_LOAD;
        else if (r_state == S_FLUSH && r_cnt != 3'd0)
            r_cnt <= r_cnt - 3'd1;
    end

    // eret keeps the previous cause so CP0 still sees the original ExcCode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exception <= 1'b0;
            r_eret      <= 1'b0;
            r_cause     <= 5'd0;
            r_epc       <= 32'd0;
            r_redirect  <= 1'b0;
        end else begin
            r_exception <= w_accept;
            r_eret      <= w_accept_instr & ex_eret;
            r_redirect  <= w_accept;
            if (w_accept) begin
                r_epc <= ex_pc;
                if (!(w_accept_instr && ex_eret))
                    r_cause <= w_code;
            end
        end
    end

    assign exception   = r_exception;
    assign eret        = r_eret;
    assign cause       = r_cause;
    assign epc         = r_epc;
    assign pc_redirect = r_redirect;
    assign flush       = (r_state == S_FLUSH);
    assign busy        = (r_state == S_FLUSH);

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - scoreboard bench for exc_ctrl
module tb_exc_ctrl;

    localparam int FLUSH_N = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_stall = 1'b0;
    logic [31:0] ex_pc = 32'd0;
    logic        ex_syscall = 1'b0;
    logic        ex_break = 1'b0;
    logic        ex_teq_trap = 1'b0;
    logic        ex_eret = 1'b0;
    logic        status_ie = 1'b0;
    logic        irq = 1'b0;
    logic        exception;
    logic        eret;
    logic [4:0]  cause;
    logic [31:0] epc;
    logic        flush;
    logic        pc_redirect;
    logic        busy;

    typedef struct {
        logic [4:0]  cause;
        logic        eret;
        logic [31:0] epc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          flush_run = 0;
    logic [4:0]  model_cause = 5'd0;

    exc_ctrl #(.FLUSH_CYCLES(FLUSH_N), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall),
        .ex_pc(ex_pc), .ex_syscall(ex_syscall), .ex_break(ex_break),
        .ex_teq_trap(ex_teq_trap), .ex_eret(ex_eret), .status_ie(status_ie),
        .irq(irq), .exception(exception), .eret(eret), .cause(cause),
        .epc(epc), .flush(flush), .pc_redirect(pc_redirect), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected event for an instruction request; cause model follows priority
    task automatic push_instr(input logic [31:0] pc, input logic s, input logic b,
                              input logic t, input logic e);
        exp_t x;
        if (!e)
            model_cause = t ? 5'd13 : b ? 5'd9 : 5'd8;
        x.cause = model_cause;
        x.eret  = e;
        x.epc   = pc;
        sb_q.push_back(x);
    endtask

    task automatic push_irq(input logic [31:0] pc);
        exp_t x;
        model_cause = 5'd0;
        x.cause = 5'd0;
        x.eret  = 1'b0;
        x.epc   = pc;
        sb_q.push_back(x);
    endtask

    task automatic clear_req();
        ex_valid = 0; ex_stall = 0; ex_syscall = 0; ex_break = 0;
        ex_teq_trap = 0; ex_eret = 0;
    endtask

    task automatic send(input logic [31:0] pc, input logic s, input logic b,
                        input logic t, input logic e);
        @(posedge clk); #1;
        ex_valid = 1; ex_pc = pc; ex_syscall = s; ex_break = b;
        ex_teq_trap = t; ex_eret = e;
        push_instr(pc, s, b, t, e);
        @(posedge clk); #1;
        clear_req();
    endtask

    task automatic wait_idle(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (k == budget) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            flush_run = 0;
        end else begin
            if (exception) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_exc", 32'(exception), 32'd0);
                end else begin
                    exp_t x;
                    x = sb_q.pop_front();
                    check("cause", 32'(cause), 32'(x.cause));
                    check("eret", 32'(eret), 32'(x.eret));
                    check("epc", epc, x.epc);
                    check("redirect", 32'(pc_redirect), 32'd1);
                    check("busy_at_exc", 32'(busy), 32'd1);
                end
            end else if (pc_redirect) begin
                check("stray_redirect", 32'(pc_redirect), 32'd0);
            end
            if (flush) begin
                flush_run++;
            end else if (flush_run != 0) begin
                check("flush_len", 32'(flush_run), 32'(FLUSH_N));
                flush_run = 0;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_exc", 32'(exception), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_epc", epc, 32'd0);
        check("rst_cause", 32'(cause), 32'd0);
        @(posedge clk); #1;
        rst = 1;

        send(32'h0040_0020, 1, 0, 0, 0);
        wait_idle(10);
        send(32'h0040_0030, 0, 1, 0, 0);
        wait_idle(10);
        send(32'h0040_0034, 0, 1, 0, 1);
        wait_idle(10);

        // teq held under stall: nothing may be accepted until stall drops
        @(posedge clk); #1;
        ex_valid = 1; ex_pc = 32'h0040_0040; ex_teq_trap = 1; ex_stall = 1;
        repeat (3) @(posedge clk);
        #1;
        check("stall_no_busy", 32'(busy), 32'd0);
        ex_stall = 0;
        push_instr(32'h0040_0040, 0, 0, 1, 0);
        @(posedge clk); #1;
        clear_req();
        wait_idle(10);

        // request held through the flush window is accepted once only
        @(posedge clk); #1;
        ex_valid = 1; ex_pc = 32'h0040_0050; ex_syscall = 1;
        push_instr(32'h0040_0050, 1, 0, 0, 0);
        repeat (FLUSH_N + 1) @(posedge clk);
        #1;
        clear_req();
        wait_idle(10);

        // invalid instruction with a request is ignored
        @(posedge clk); #1;
        ex_pc = 32'h0040_0060; ex_break = 1;
        repeat (2) @(posedge clk);
        #1;
        check("invalid_ignored", 32'(busy), 32'd0);
        clear_req();

`ifdef IRQ_EN
        irq = 1; status_ie = 0; ex_valid = 1; ex_pc = 32'h0040_00f0;
        repeat (10) @(posedge clk);
        #1;
        check("irq_masked", 32'(busy), 32'd0);
        status_ie = 1; ex_pc = 32'h0040_0100;
        push_irq(32'h0040_0100);
        @(posedge clk); #1;
        ex_pc = 32'h0040_0104;
        repeat (8) @(posedge clk);
        #1;
        irq = 0; ex_valid = 0;
        repeat (5) @(posedge clk);
        #1;
        irq = 1; ex_valid = 1; ex_pc = 32'h0040_0200; ex_syscall = 1;
        push_instr(32'h0040_0200, 1, 0, 0, 0);
        push_irq(32'h0040_0204);
        @(posedge clk); #1;
        ex_syscall = 0; ex_pc = 32'h0040_0204;
        repeat (10) @(posedge clk);
        #1;
        clear_req(); irq = 0; status_ie = 0;
        wait_idle(10);
`endif

        // reset during the first flush cycle drops the event immediately
        @(posedge clk); #1;
        ex_valid = 1; ex_pc = 32'h0040_0300; ex_syscall = 1;
        @(posedge clk); #2;
        clear_req();
        rst = 0;
        #1;
        check("midrst_exc", 32'(exception), 32'd0);
        check("midrst_flush", 32'(flush), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_epc", epc, 32'd0);
        model_cause = 5'd0;
        @(posedge clk); #1;
        rst = 1;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_busy", 32'(busy), 32'd0);

        send(32'h0040_0400, 0, 0, 1, 0);
        wait_idle(10);
        repeat (3) @(posedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
